cmp_pipe: RTL and testbench
===========================

Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator in the NPC execute path.
- Compares two WIDTH-bit operands.
- Produces both a 1-bit condition, for branches and SLT/SLTU, and a WIDTH-bit selected value, for Zbb MIN/MAX.
- Two registered stages with valid/ready handshake on both sides.
- Carries a tag for the issuing instruction; flush kills in-flight operations on redirect.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits per stage-1 partial comparator; NCHUNK = WIDTH/CHUNK.
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  block can accept this cycle.
- in_a_i  in  WIDTH  operand a.
- in_b_i  in  WIDTH  operand b.
- in_op_i  in  4  operation code, see Behaviour.
- in_tag_i  in  TAG_W  tag, returned unchanged.
- flush_i  in  1  kill all in-flight operations.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts.
- out_flag_o  out  1  condition result.
- out_value_o  out  WIDTH  selected operand (MIN/MAX), else zero-extended flag.
- out_tag_o  out  TAG_W  tag of the result.

Behaviour:
- One clock domain: clk_i. Reset rst_i is synchronous and active-high.
- Op encoding, defined in cmp_pkg:
  - 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU (RISC-V funct3 values).
  - 8 SLT, 9 SLTU.
  - 10 MIN, 11 MAX, 12 MINU, 13 MAXU.
  - Codes 2, 3, 14 and 15 are illegal: out_flag=0, out_value=0, still consumed normally.
- Stage 1, registered on accept:
  - Per chunk k, latch eq_k = (a_k == b_k) and ltu_k = (a_k < b_k) unsigned.
  - Also latch sign bits a[W-1], b[W-1], both operands, op and tag.
- Stage 2, registered, combines chunks MSB-first:
  - eq = AND of all eq_k.
  - ltu = ltu_k of the highest chunk whose eq_k is 0; 0 if all chunks are equal.
  - lt (signed) = (a_msb & ~b_msb) | ((a_msb == b_msb) & ltu).
- Flag per op:
  - EQ = eq; NE = ~eq.
  - LT and SLT = lt; GE = ~lt.
  - LTU and SLTU = ltu; GEU = ~ltu.
  - MIN/MAX/MINU/MAXU: flag = the relevant lt/ltu.
- Value per op:
  - MIN = lt ? a : b; MAX = lt ? b : a.
  - MINU = ltu ? a : b; MAXU = ltu ? b : a.
  - Equal operands: MIN/MAX return a (identical bits).
  - All other ops: value = {WIDTH-1 zeros, flag}.
- Latency: 2 cycles from accept to out_valid_o when unstalled. Throughput 1 op/cycle.
- Handshake:
  - s2_adv = ~s2_valid | out_ready_i.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready_o = s1_adv. This is a combinational path from out_ready_i; it is permitted.
  - Transfer occurs when valid & ready. Outputs are held stable while out_valid_o=1 & out_ready_i=0.
- Flush:
  - flush_i=1 clears s1_valid and s2_valid next cycle.
  - An input offered in the same cycle as flush is not captured.
  - in_ready_o stays as computed, so the producer sees the transfer as done and the op is dropped.
  - out_valid_o may be high in the flush cycle; the consumer must ignore it.
- Reset: s1_valid=0, s2_valid=0, out_valid_o=0, out_flag_o=0, out_value_o=0, out_tag_o=0. Reset overrides flush and input.
- Data registers are loaded only on advance. out_* data is cleared only by reset.

Decomposition:
- cmp_pkg holds:
  - op localparams (OP_EQ … OP_MAXU);
  - a function is_unsigned(op);
  - a function is_minmax(op);
  - a function op_legal(op).
- Sub-module cmp_chunk (CHUNK-bit eq/ltu pair, purely combinational) is instantiated NCHUNK times in stage 1.
- Stage 2 combine and handshake logic stay in cmp_pipe.

Test Plan:
- Reset, then single op BLT a=0xFFFFFFFF, b=0x00000001, tag=3 -> two cycles later out_valid=1, flag=1, value=1, tag=3. Repeat as LTU -> flag=0.
- Back-to-back stream, out_ready=1:
  - MIN(0x80000000, 0x7FFFFFFF) -> 0x80000000.
  - MAXU(0x80000000, 0x7FFFFFFF) -> 0x80000000.
  - EQ(0x12345678, 0x12345678) -> flag=1.
  - Check one result/cycle, in order, tags preserved.
- Back-pressure: hold out_ready=0 for 4 cycles with 3 ops offered -> in_ready drops after 2 accepted. Output is stable during the stall. On release, 3 results appear in order; none are lost or duplicated.
- Chunk boundary: a=0x00010000, b=0x0000FFFF with LTU -> flag=0. a=0x0000FF00, b=0x0000FF01 with LTU -> flag=1 (difference only in the lowest chunk).
- Flush with both stages full and a new op offered -> next cycle out_valid=0. The offered op never appears; a subsequent op completes normally.
- Illegal op 2, plus reset asserted mid-stall with s2 full -> illegal op gives flag=0, value=0. Reset gives all outputs 0 next cycle and in_ready=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined comparator: op codes and op-class helpers.
package cmp_pkg;

  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  // Branch conditions reuse the RISC-V funct3 values.
  localparam op_t OP_EQ   = 4'd0;
  localparam op_t OP_NE   = 4'd1;
  localparam op_t OP_LT   = 4'd4;
  localparam op_t OP_GE   = 4'd5;
  localparam op_t OP_LTU  = 4'd6;
  localparam op_t OP_GEU  = 4'd7;
  localparam op_t OP_SLT  = 4'd8;
  localparam op_t OP_SLTU = 4'd9;
  localparam op_t OP_MIN  = 4'd10;
  localparam op_t OP_MAX  = 4'd11;
  localparam op_t OP_MINU = 4'd12;
  localparam op_t OP_MAXU = 4'd13;

  // Ops whose ordering decision uses the unsigned compare.
  function automatic logic is_unsigned(input op_t op);
    return (op == OP_LTU) || (op == OP_GEU) || (op == OP_SLTU) ||
           (op == OP_MINU) || (op == OP_MAXU);
  endfunction

  // Ops that return one of the operands instead of a flag.
  function automatic logic is_minmax(input op_t op);
    return (op == OP_MIN) || (op == OP_MAX) || (op == OP_MINU) || (op == OP_MAXU);
  endfunction

  // Codes 2, 3, 14 and 15 are unassigned; they are consumed but produce zero.
  function automatic logic op_legal(input op_t op);
    return !((op == 4'd2) || (op == 4'd3) || (op == 4'd14) || (op == 4'd15));
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One slice of the stage-1 comparator: equality and unsigned less-than of a chunk.
module cmp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         ltu
);

  assign eq  = (a == b);
  assign ltu = (a < b);

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator for branches, SLT/SLTU and Zbb MIN/MAX.
// Stage 1 registers per-chunk eq/ltu partials; stage 2 merges them MSB-first
// and registers the final flag/value. WIDTH must be a multiple of CHUNK.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [3:0]       in_op_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_flag_o,
  output logic [WIDTH-1:0] out_value_o,
  output logic [TAG_W-1:0] out_tag_o
);

  localparam int NCHUNK = WIDTH / CHUNK;

  logic [NCHUNK-1:0] chunk_eq;
  logic [NCHUNK-1:0] chunk_ltu;

  logic              s1_valid;
  logic [NCHUNK-1:0] s1_eq;
  logic [NCHUNK-1:0] s1_ltu;
  logic              s1_a_msb;
  logic              s1_b_msb;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  op_t               s1_op;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid;
  logic              s2_flag;
  logic [WIDTH-1:0]  s2_value;
  logic [TAG_W-1:0]  s2_tag;

  logic              s1_adv;
  logic              s2_adv;

  logic              eq_all;
  logic              ltu_all;
  logic              lt_all;
  logic              sel_lt;
  logic              flag_c;
  logic [WIDTH-1:0]  value_c;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    cmp_chunk #(.W(CHUNK)) u_chunk (
      .a   (in_a_i[k*CHUNK +: CHUNK]),
      .b   (in_b_i[k*CHUNK +: CHUNK]),
      .eq  (chunk_eq[k]),
      .ltu (chunk_ltu[k])
    );
  end

  // A stage may advance when it is empty or its successor is advancing.
  assign s2_adv     = ~s2_valid | out_ready_i;
  assign s1_adv     = ~s1_valid | s2_adv;
  assign in_ready_o = s1_adv;

  assign out_valid_o = s2_valid;
  assign out_flag_o  = s2_flag;
  assign out_value_o = s2_value;
  assign out_tag_o   = s2_tag;

  // Stage-1 occupancy: flush drops both the in-flight op and any op offered now.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
    end
  end

  // Stage-1 payload: chunk partials, sign bits, operands, op and tag on accept.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && s1_adv && in_valid_i) begin
      s1_eq    <= chunk_eq;
      s1_ltu   <= chunk_ltu;
      s1_a_msb <= in_a_i[WIDTH-1];
      s1_b_msb <= in_b_i[WIDTH-1];
      s1_a     <= in_a_i;
      s1_b     <= in_b_i;
      s1_op    <= op_t'(in_op_i);
      s1_tag   <= in_tag_i;
    end
  end

  // Merge chunk partials: the highest differing chunk decides the unsigned order.
  always_comb begin
    eq_all  = &s1_eq;
    ltu_all = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (!s1_eq[k]) begin
        ltu_all = s1_ltu[k];
      end
    end
    lt_all = (s1_a_msb & ~s1_b_msb) | ((s1_a_msb == s1_b_msb) & ltu_all);
  end

  // Condition flag and result value for the op held in stage 1.
  always_comb begin
    flag_c  = 1'b0;
    value_c = '0;
    sel_lt  = is_unsigned(s1_op) ? ltu_all : lt_all;
    case (s1_op)
      OP_EQ:                 flag_c = eq_all;
      OP_NE:                 flag_c = ~eq_all;
      OP_LT,  OP_SLT:        flag_c = lt_all;
      OP_GE:                 flag_c = ~lt_all;
      OP_LTU, OP_SLTU:       flag_c = ltu_all;
      OP_GEU:                flag_c = ~ltu_all;
      OP_MIN, OP_MAX,
      OP_MINU, OP_MAXU:      flag_c = sel_lt;
      default:               flag_c = 1'b0;
    endcase
    if (!op_legal(s1_op)) begin
      flag_c = 1'b0;
    end
    if (is_minmax(s1_op)) begin
      if ((s1_op == OP_MIN) || (s1_op == OP_MINU)) begin
        value_c = sel_lt ? s1_a : s1_b;
      end else begin
        value_c = sel_lt ? s1_b : s1_a;
      end
    end else begin
      value_c[0] = flag_c;
    end
  end

  // Output stage: holds its result until the consumer takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_flag  <= 1'b0;
      s2_value <= '0;
      s2_tag   <= '0;
    end else begin
      if (flush_i) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (!flush_i && s2_adv && s1_valid) begin
        s2_flag  <= flag_c;
        s2_value <= value_c;
        s2_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: directed vectors, stall/flush/reset
// sequences and a randomized stream scored against an in-order reference queue.
module tb_cmp_pipe;
  import cmp_pkg::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_flag;
  logic [WIDTH-1:0] out_value;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;

  typedef struct {
    logic             flag;
    logic [WIDTH-1:0] value;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    logic             flag;
    logic [WIDTH-1:0] value;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  cmp_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_op_i     (in_op),
    .in_tag_i    (in_tag),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_flag_o  (out_flag),
    .out_value_o (out_value),
    .out_tag_o   (out_tag)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle counter used to age entries in the reference queue.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference result computed straight from the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic slt;
    logic ult;
    slt = ($signed(a) < $signed(b));
    ult = (a < b);
    e.flag  = 1'b0;
    e.value = '0;
    e.tag   = tag;
    e.acc   = 0;
    case (op)
      4'd0:        e.flag = (a == b);
      4'd1:        e.flag = (a != b);
      4'd4, 4'd8:  e.flag = slt;
      4'd5:        e.flag = !slt;
      4'd6, 4'd9:  e.flag = ult;
      4'd7:        e.flag = !ult;
      4'd10: begin e.flag = slt; e.value = ($signed(a) <= $signed(b)) ? a : b; end
      4'd11: begin e.flag = slt; e.value = ($signed(a) >= $signed(b)) ? a : b; end
      4'd12: begin e.flag = ult; e.value = (a <= b) ? a : b; end
      4'd13: begin e.flag = ult; e.value = (a >= b) ? a : b; end
      default:     e.flag = 1'b0;
    endcase
    if (!(op >= 4'd10 && op <= 4'd13)) e.value = {{(WIDTH-1){1'b0}}, e.flag};
    return e;
  endfunction

  // Scoreboard: ready/valid predicted from occupancy, results in order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check_output("mon_ready", in_ready, (q.size() < 2) || out_ready);
      check_output("mon_valid", out_valid, (q.size() > 0) && (cyc - q[0].acc >= 2));
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && q.size() > 0) begin
          check_output("mon_flag", out_flag, q[0].flag);
          check_output("mon_value", out_value, q[0].value);
          check_output("mon_tag", out_tag, q[0].tag);
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e = model(in_op, in_a, in_b, in_tag);
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Single op into an empty pipe: check the two-cycle latency and the result.
  task automatic run_vector(input vec_t v);
    @(posedge clk); #1;
    out_ready = 1'b1;
    apply_stimulus(v.op, v.a, v.b, v.tag);
    @(negedge clk);
    check_output("vec_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("vec_early_valid", out_valid, 0);
    @(negedge clk);
    check_output("vec_valid", out_valid, 1);
    check_output("vec_flag", out_flag, v.flag);
    check_output("vec_value", out_value, v.value);
    check_output("vec_tag", out_tag, v.tag);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("drain_empty", q.size(), 0);
  endtask

  initial begin
    int p0;
    vecs[0]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 5'd3,  1'b1, 32'h1};
    vecs[1]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 5'd4,  1'b0, 32'h0};
    vecs[2]  = '{4'd10, 32'h80000000, 32'h7FFFFFFF, 5'd5,  1'b1, 32'h80000000};
    vecs[3]  = '{4'd13, 32'h80000000, 32'h7FFFFFFF, 5'd6,  1'b0, 32'h80000000};
    vecs[4]  = '{4'd0,  32'h12345678, 32'h12345678, 5'd7,  1'b1, 32'h1};
    vecs[5]  = '{4'd6,  32'h00010000, 32'h0000FFFF, 5'd8,  1'b0, 32'h0};
    vecs[6]  = '{4'd6,  32'h0000FF00, 32'h0000FF01, 5'd9,  1'b1, 32'h1};
    vecs[7]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd10, 1'b0, 32'h0};
    vecs[8]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd11, 1'b1, 32'h1};
    vecs[9]  = '{4'd1,  32'h00000005, 32'h00000005, 5'd12, 1'b0, 32'h0};
    vecs[10] = '{4'd8,  32'h7FFFFFFF, 32'h80000000, 5'd13, 1'b0, 32'h0};
    vecs[11] = '{4'd9,  32'h00000000, 32'h00000001, 5'd14, 1'b1, 32'h1};
    vecs[12] = '{4'd11, 32'h00000005, 32'h00000005, 5'd15, 1'b0, 32'h5};
    vecs[13] = '{4'd12, 32'h00000003, 32'hFFFFFFFF, 5'd16, 1'b1, 32'h3};
    vecs[14] = '{4'd14, 32'h00000001, 32'h00000002, 5'd17, 1'b0, 32'h0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_flag", out_flag, 0);
    check_output("rst_value", out_value, 0);
    check_output("rst_tag", out_tag, 0);
    check_output("rst_ready", in_ready, 1);

    for (int i = 0; i < NVEC; i++) run_vector(vecs[i]);
    drain();

    // Back-to-back stream: one result per cycle, in order.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < 3) apply_stimulus(vecs[2+i].op, vecs[2+i].a, vecs[2+i].b, vecs[2+i].tag);
      else in_valid = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        check_output("stream_valid", out_valid, 1);
        check_output("stream_value", out_value, vecs[i].value);
        check_output("stream_tag", out_tag, vecs[i].tag);
      end
    end
    drain();

    // Back-pressure: two ops fill the pipe, the third waits for the release.
    p0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply_stimulus(4'd10, 32'h80000000, 32'h7FFFFFFF, 5'd1);
    @(negedge clk); check_output("bp_ready_a", in_ready, 1);
    @(posedge clk); #1 apply_stimulus(4'd13, 32'h80000000, 32'h7FFFFFFF, 5'd2);
    @(negedge clk); check_output("bp_ready_b", in_ready, 1);
    @(posedge clk); #1 apply_stimulus(4'd0, 32'h12345678, 32'h12345678, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("bp_ready_full", in_ready, 0);
      check_output("bp_hold_value", out_value, 32'h80000000);
      check_output("bp_hold_tag", out_tag, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); check_output("bp_ready_release", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("bp_pops", pops - p0, 3);
    check_output("bp_empty", q.size(), 0);

    // Flush with both stages full and a new op offered in the same cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply_stimulus(4'd4, 32'h1, 32'h2, 5'd20);
    @(posedge clk); #1 apply_stimulus(4'd6, 32'h3, 32'h2, 5'd21);
    @(posedge clk); #1;
    apply_stimulus(4'd0, 32'h7, 32'h7, 5'd22);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); check_output("fl_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("fl_no_output", out_valid, 0);
    end
    run_vector(vecs[4]);
    drain();

    // Randomized stream with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int mode;
      @(posedge clk); #1;
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 3);
      if (mode == 1) rb = ra;
      else if (mode == 2) rb = ra ^ (32'h1 << $urandom_range(0, WIDTH-1));
      else if (mode == 3) rb = {ra[31:16], rb[15:0]};
      apply_stimulus(4'($urandom_range(0, 15)), ra, rb, 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    drain();

    // Illegal op, then reset while the output is stalled with s2 full.
    run_vector(vecs[14]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply_stimulus(4'd11, 32'h55, 32'h10, 5'd7);
    @(posedge clk); #1 apply_stimulus(4'd12, 32'h1, 32'h2, 5'd8);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("pre_rst_value", out_value, 32'h55);
    check_output("pre_rst_tag", out_tag, 7);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_flag", out_flag, 0);
    check_output("mid_rst_value", out_value, 0);
    check_output("mid_rst_tag", out_tag, 0);
    check_output("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
